pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard detection and stall control
//
// Purpose: detects D-stage data hazards against the E and M producers using
// Tuse/Tnew timing. Optionally tracks the busy window of a multi-cycle
// multiply/divide unit and stalls D-stage MDU instructions against it. It also
// keeps a saturating count of stall cycles.
// The MDU tracking is built only when PIPE_HAZARD_CTRL_MDU_EN is defined.
// Otherwise md_cnt/md_busy read 0 and the MDU inputs are ignored.
//
// Ports:
//   clk, reset                 clock (posedge), synchronous active-high reset
//   d_rs_addr/d_rt_addr        source registers of the D instruction
//   d_rs_use/d_rt_use          D instruction actually reads rs / rt
//   d_tuse_rs/d_tuse_rt        cycles until D needs rs / rt
//   e_wa/e_tnew, m_wa/m_tnew   destination and result readiness of E / M
//   d_md_use                   D instruction touches the MDU or HI/LO
//   e_md_start/e_md_op         E starts mult (op=0) or div (op=1)
//   stall/pc_en/fd_en/de_flush pipeline freeze and bubble controls
//   md_busy/md_cnt             MDU busy flag and remaining busy cycles
//   stall_cnt                  saturating count of stalled cycles

module pipe_hazard_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  d_rs_addr,
   input  logic [4:0]  d_rt_addr,
   input  logic        d_rs_use,
   input  logic        d_rt_use,
   input  logic [1:0]  d_tuse_rs,
   input  logic [1:0]  d_tuse_rt,
   input  logic [4:0]  e_wa,
   input  logic [1:0]  e_tnew,
   input  logic [4:0]  m_wa,
   input  logic [1:0]  m_tnew,
   input  logic        d_md_use,
   input  logic        e_md_start,
   input  logic        e_md_op,
   output logic        stall,
   output logic        pc_en,
   output logic        fd_en,
   output logic        de_flush,
   output logic        md_busy,
   output logic [3:0]  md_cnt,
   output logic [15:0] stall_cnt
);

   logic        rs_stall;
   logic        rt_stall;
   logic        data_stall;
   logic        md_stall;
   logic [15:0] stall_cnt_q;
   logic [15:0] stall_cnt_d;

   // A source stalls only if the matching producer's result arrives later
   // than the D instruction needs it. $0 never matches.
   always_comb begin
      rs_stall = 1'b0;
      rt_stall = 1'b0;
      if (d_rs_use && (d_rs_addr != 5'd0)) begin
         rs_stall = ((d_rs_addr == e_wa) && (e_tnew > d_tuse_rs)) ||
                    ((d_rs_addr == m_wa) && (m_tnew > d_tuse_rs));
      end
      if (d_rt_use && (d_rt_addr != 5'd0)) begin
         rt_stall = ((d_rt_addr == e_wa) && (e_tnew > d_tuse_rt)) ||
                    ((d_rt_addr == m_wa) && (m_tnew > d_tuse_rt));
      end
      data_stall = rs_stall || rt_stall;
   end

`ifdef PIPE_HAZARD_CTRL_MDU_EN
   logic [3:0] md_cnt_q;
   logic [3:0] md_cnt_d;

   // A start is accepted only when idle; starts during a busy window are
   // dropped silently.
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (md_cnt_q == 4'd0) begin
         if (e_md_start) begin
            md_cnt_d = e_md_op ? 4'd10 : 4'd5;
         end
      end else begin
         md_cnt_d = md_cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt_q <= 4'd0;
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end

   assign md_cnt   = md_cnt_q;
   assign md_busy  = (md_cnt_q != 4'd0);
   // e_md_start counts as busy too, so an MDU op directly behind the
   // starting instruction sees the unit before the counter is loaded.
   assign md_stall = d_md_use && (md_busy || e_md_start);
`else
   logic unused_md_inputs;

   assign unused_md_inputs = ^{d_md_use, e_md_start, e_md_op};
   assign md_cnt   = 4'd0;
   assign md_busy  = 1'b0;
   assign md_stall = 1'b0;
`endif

   assign stall    = data_stall || md_stall;
   assign pc_en    = ~stall;
   assign fd_en    = ~stall;
   assign de_flush = stall;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_MDU_EN
   localparam bit MDU_EN = 1'b1;
`else
   localparam bit MDU_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  d_rs_addr, d_rt_addr, e_wa, m_wa;
   logic        d_rs_use, d_rt_use, d_md_use, e_md_start, e_md_op;
   logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
   logic        stall, pc_en, fd_en, de_flush, md_busy;
   logic [3:0]  md_cnt;
   logic [15:0] stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: absolute cycle numbers rather than a countdown.
   int now = 0;
   int md_free_at = 0;
   int exp_stalls = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
      .d_rs_use(d_rs_use), .d_rt_use(d_rt_use),
      .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
      .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew),
      .d_md_use(d_md_use), .e_md_start(e_md_start), .e_md_op(e_md_op),
      .stall(stall), .pc_en(pc_en), .fd_en(fd_en), .de_flush(de_flush),
      .md_busy(md_busy), .md_cnt(md_cnt), .stall_cnt(stall_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, now);
      end
   endtask

   function automatic int exp_md_cnt();
      return (md_free_at > now) ? (md_free_at - now) : 0;
   endfunction

   function automatic bit exp_data_stall();
      int src[2], use_[2], tuse[2], dst[2], tnew[2];
      bit s = 1'b0;
      src[0] = int'(d_rs_addr); use_[0] = int'(d_rs_use); tuse[0] = int'(d_tuse_rs);
      src[1] = int'(d_rt_addr); use_[1] = int'(d_rt_use); tuse[1] = int'(d_tuse_rt);
      dst[0] = int'(e_wa); tnew[0] = int'(e_tnew);
      dst[1] = int'(m_wa); tnew[1] = int'(m_tnew);
      foreach (src[i])
         foreach (dst[j])
            if (use_[i] != 0 && src[i] != 0 && src[i] == dst[j] && tnew[j] > tuse[i])
               s = 1'b1;
      return s;
   endfunction

   function automatic bit exp_stall();
      bit md = MDU_EN && d_md_use && (exp_md_cnt() != 0 || e_md_start);
      return exp_data_stall() || md;
   endfunction

   task automatic clear_inputs();
      d_rs_addr = 0; d_rt_addr = 0; d_rs_use = 0; d_rt_use = 0;
      d_tuse_rs = 0; d_tuse_rt = 0; e_wa = 0; e_tnew = 0; m_wa = 0; m_tnew = 0;
      d_md_use = 0; e_md_start = 0; e_md_op = 0;
   endtask

   // Called 1 time unit after a posedge: move to mid-cycle and compare all outputs.
   task automatic settle(input bit do_check);
      bit s;
      #4;
      if (do_check) begin
         s = exp_stall();
         check("stall", stall, s);
         check("pc_en", pc_en, !s);
         check("fd_en", fd_en, !s);
         check("de_flush", de_flush, s);
         check("md_busy", md_busy, exp_md_cnt() != 0);
         check("md_cnt", md_cnt, exp_md_cnt());
         check("stall_cnt", stall_cnt, exp_stalls);
      end
   endtask

   // Apply the clock edge to the model, then step the DUT to posedge+1.
   task automatic advance();
      bit s = exp_stall();
      if (reset) begin
         md_free_at = now + 1;
         exp_stalls = 0;
      end else begin
         if (MDU_EN && e_md_start && exp_md_cnt() == 0)
            md_free_at = now + 1 + (e_md_op ? 10 : 5);
         if (s && exp_stalls < 65535)
            exp_stalls++;
      end
      now++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      clear_inputs();
      reset = 1;
      @(posedge clk);
      #1;
      advance();
      settle(1);
      check("rst_md_cnt", md_cnt, 0);
      check("rst_stall_cnt", stall_cnt, 0);
      advance();
      reset = 0;

      // lw-use: load in E, then in M with tnew=1, then ready.
      e_wa = 8; e_tnew = 2; d_rs_addr = 8; d_rs_use = 1; d_tuse_rs = 0;
      settle(1);
      check("lwuse_stall", stall, 1);
      check("lwuse_pc_en", pc_en, 0);
      check("lwuse_flush", de_flush, 1);
      advance();
      e_wa = 0; e_tnew = 0; m_wa = 8; m_tnew = 1;
      settle(1);
      check("lwuse_m_stall", stall, 1);
      advance();
      m_tnew = 0;
      settle(1);
      check("lwuse_done", stall, 0);
      advance();

      // $0 immunity.
      clear_inputs();
      e_wa = 0; e_tnew = 2; d_rs_addr = 0; d_rs_use = 1;
      settle(1);
      check("zero_reg", stall, 0);
      advance();

      // Forwardable in time: no stall.
      clear_inputs();
      e_wa = 9; e_tnew = 1; d_rt_addr = 9; d_rt_use = 1; d_tuse_rt = 1;
      settle(1);
      check("fwd_ok", stall, 0);
      advance();

      // div followed by dependent MDU ops.
      clear_inputs();
      e_md_start = 1; e_md_op = 1; d_md_use = 1;
      settle(1);
      check("div_T_stall", stall, MDU_EN);
      advance();
      e_md_start = 0;
      for (int k = 1; k <= 11; k++) begin
         settle(1);
         check("div_cnt", md_cnt, MDU_EN ? 11 - k : 0);
         check("div_stall", stall, MDU_EN && k <= 10);
         advance();
      end

      // Reset in the middle of a div.
      clear_inputs();
      e_md_start = 1; e_md_op = 1;
      settle(1);
      advance();
      e_md_start = 0;
      for (int k = 0; k < 4; k++) begin
         settle(1);
         advance();
      end
      reset = 1;
      settle(1);
      check("middiv_cnt", md_cnt, MDU_EN ? 6 : 0);
      advance();
      reset = 0;
      settle(1);
      check("middiv_rst_cnt", md_cnt, 0);
      check("middiv_rst_busy", md_busy, 0);
      check("middiv_rst_stalls", stall_cnt, 0);
      advance();

      // Randomized traffic on a small register set to provoke collisions.
      for (int n = 0; n < 2000; n++) begin
         reset      = ($urandom_range(0, 149) == 0);
         d_rs_addr  = 5'($urandom_range(0, 3));
         d_rt_addr  = 5'($urandom_range(0, 3));
         e_wa       = 5'($urandom_range(0, 3));
         m_wa       = 5'($urandom_range(0, 3));
         d_rs_use   = 1'($urandom_range(0, 1));
         d_rt_use   = 1'($urandom_range(0, 1));
         d_tuse_rs  = 2'($urandom_range(0, 2));
         d_tuse_rt  = 2'($urandom_range(0, 2));
         e_tnew     = 2'($urandom_range(0, 2));
         m_tnew     = 2'($urandom_range(0, 1));
         d_md_use   = 1'($urandom_range(0, 1));
         e_md_start = ($urandom_range(0, 5) == 0);
         e_md_op    = 1'($urandom_range(0, 1));
         settle(1);
         advance();
      end

      // Saturation: hold a data hazard past 65535 stall cycles.
      clear_inputs();
      reset = 1;
      settle(1);
      advance();
      reset = 0;
      e_wa = 8; e_tnew = 2; d_rs_addr = 8; d_rs_use = 1;
      for (int n = 0; n < 65600; n++) begin
         settle(n % 4096 == 0);
         advance();
      end
      settle(1);
      check("sat_hold", stall_cnt, 16'hFFFF);
      advance();
      settle(1);
      check("sat_hold2", stall_cnt, 16'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
